// File: rtl/data_mem_responder.sv
// Doubleword data memory with a fixed, parameterised access latency.
// Requests are captured in IDLE, counted down in ACCESS and acknowledged from DONE.
module data_mem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [63:0] Address,
    input  logic [63:0] WriteData,
    output logic [63:0] ReadData,
    output logic        Ready,
    output logic        Busy,
    output logic        Error
);

    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] LIMIT    = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic               is_wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [63:0]        wdata_q;
    logic [63:0]        rdata_q;
    logic               ready_q;
    logic               busy_q;
    logic               error_q;
    logic [63:0]        mem_q [DEPTH];

    logic req_any;
    logic req_legal;

    // Only a single strobe to an aligned, in-range doubleword is accepted.
    always_comb begin
        req_any   = MemRead | MemWrite;
        req_legal = (MemRead ^ MemWrite) && (Address[2:0] == 3'b000) && (Address < LIMIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_legal) begin
                        state_q <= ACCESS;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_INIT;
                        is_wr_q <= MemWrite;
                        idx_q   <= Address[IDX_W+2:3];
                        wdata_q <= WriteData;
                    end else if (req_any) begin
                        error_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // Access happens on the edge that enters DONE so data and Ready align.
                        if (is_wr_q) begin
                            mem_q[idx_q] <= wdata_q;
                        end else begin
                            rdata_q <= mem_q[idx_q];
                        end
                        state_q <= DONE;
                        ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ReadData = rdata_q;
    assign Ready    = ready_q;
    assign Busy     = busy_q;
    assign Error    = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus queues expected completions/errors with their cycle,
// a negedge monitor pops and compares whenever a DUT raises Ready or Error.
module tb_data_mem_responder;

    localparam int KW = 0;  // write completion
    localparam int KR = 1;  // read completion
    localparam int KE = 2;  // error pulse

    typedef struct {
        int          dut;
        int          kind;
        int          cyc;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [63:0] addr0 = '0, wd0 = '0, addr1 = '0, wd1 = '0;
    logic [63:0] rdata0, rdata1;
    logic        rdy0, busy0, err0, rdy1, busy1, err1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    data_mem_responder #(.DEPTH(32), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset_n(rst_n), .MemRead(rd0), .MemWrite(wr0),
        .Address(addr0), .WriteData(wd0), .ReadData(rdata0),
        .Ready(rdy0), .Busy(busy0), .Error(err0)
    );

    data_mem_responder #(.DEPTH(32), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(rst_n), .MemRead(rd1), .MemWrite(wr1),
        .Address(addr1), .WriteData(wd1), .ReadData(rdata1),
        .Ready(rdy1), .Busy(busy1), .Error(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input logic rdy, input logic err, input logic [63:0] rd);
        exp_t e;
        if (rdy || err) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: dut%0d ready=%b error=%b got nothing expected", d, rdy, err);
            end else begin
                e = q.pop_front();
                chk("resp_dut", 64'(d), 64'(e.dut));
                chk("resp_is_error", {63'd0, err}, {63'd0, e.kind == KE});
                chk("resp_ready", {63'd0, rdy}, {63'd0, e.kind != KE});
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                if (e.kind == KR) chk("resp_rdata", rd, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, rdy0, err0, rdata0);
            mon(1, rdy1, err1, rdata1);
        end
    end

    task automatic drive(input int d, input logic r, input logic w, input logic [63:0] a, input logic [63:0] wd);
        if (d == 0) begin rd0 = r; wr0 = w; addr0 = a; wd0 = wd; end
        else begin rd1 = r; wr1 = w; addr1 = a; wd1 = wd; end
    endtask

    task automatic push(input int d, input int kind, input int c, input logic [63:0] data);
        exp_t e;
        e.dut = d; e.kind = kind; e.cyc = c; e.data = data;
        q.push_back(e);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (((d == 0) ? busy0 : busy1) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) chk("idle_timeout", 64'(n), 64'd0);
        @(negedge clk);
    endtask

    // Issue one request at the next negedge; the sampling edge follows.
    task automatic issue(input int d, input logic r, input logic w, input logic [63:0] a,
                         input logic [63:0] wd, input int kind, input logic [63:0] rexp);
        int lat;
        lat = (d == 0) ? 2 : 1;
        @(negedge clk);
        drive(d, r, w, a, wd);
        push(d, kind, (kind == KE) ? cyc + 1 : cyc + 1 + lat, rexp);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, a, wd);
        wait_idle(d);
    endtask

    initial begin
        #1;
        chk("rst_rdata0", rdata0, 64'd0);
        chk("rst_outs0", {61'd0, rdy0, busy0, err0}, 64'd0);
        chk("rst_outs1", {61'd0, rdy1, busy1, err1}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back with LATENCY=2.
        issue(0, 1'b0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, KW, 64'd0);
        issue(0, 1'b1, 1'b0, 64'h10, 64'd0, KR, 64'hDEADBEEF_CAFEF00D);

        // Rejected requests: both strobes, misaligned, out of range.
        issue(0, 1'b1, 1'b1, 64'h08, 64'h1111, KE, 64'd0);
        issue(0, 1'b1, 1'b0, 64'h0C, 64'd0, KE, 64'd0);
        issue(0, 1'b1, 1'b0, 64'h100, 64'd0, KE, 64'd0);
        chk("rdata_after_errors", rdata0, 64'hDEADBEEF_CAFEF00D);
        issue(0, 1'b1, 1'b0, 64'h08, 64'd0, KR, 64'd0);

        // Second write during ACCESS must be ignored.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 64'h18, 64'hAAAA_0000_0000_0001);
        push(0, KW, cyc + 3, 64'd0);
        @(negedge clk);
        chk("busy_in_access", {63'd0, busy0}, 64'd1);
        drive(0, 1'b0, 1'b1, 64'h18, 64'hBBBB_0000_0000_0002);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 64'h18, 64'd0);
        wait_idle(0);
        issue(0, 1'b1, 1'b0, 64'h18, 64'd0, KR, 64'hAAAA_0000_0000_0001);

        // Reset in the middle of a write's ACCESS phase.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 64'h20, 64'h1234);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 64'h20, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdata", rdata0, 64'd0);
        chk("midrst_outs", {61'd0, rdy0, busy0, err0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue(0, 1'b1, 1'b0, 64'h20, 64'd0, KR, 64'd0);
        issue(0, 1'b1, 1'b0, 64'h10, 64'd0, KR, 64'd0);

        // Last entry versus first entry.
        issue(0, 1'b0, 1'b1, 64'hF8, 64'hFFFF_FFFF_FFFF_FFFF, KW, 64'd0);
        issue(0, 1'b1, 1'b0, 64'hF8, 64'd0, KR, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(0, 1'b1, 1'b0, 64'h00, 64'd0, KR, 64'd0);

        // LATENCY=1 instance: single read, then held MemRead every 3 cycles.
        issue(1, 1'b1, 1'b0, 64'h00, 64'd0, KR, 64'd0);
        issue(1, 1'b0, 1'b1, 64'h08, 64'h5555_6666_7777_8888, KW, 64'd0);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 64'h08, 64'd0);
        push(1, KR, cyc + 2, 64'h5555_6666_7777_8888);
        push(1, KR, cyc + 5, 64'h5555_6666_7777_8888);
        push(1, KR, cyc + 8, 64'h5555_6666_7777_8888);
        repeat (8) @(negedge clk);
        drive(1, 1'b0, 1'b0, 64'h08, 64'd0);
        wait_idle(1);

        repeat (5) @(negedge clk);
        chk("all_responses_seen", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the number of 64-bit doubleword entries.
REQ-002 The block SHALL have parameter LATENCY, default 2, legal range 1..15, giving the cycles from request sample to access.

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 MemRead  input  1  read request from control/datapath.
REQ-006 MemWrite  input  1  write request from control/datapath.
REQ-007 Address  input  64  byte address, doubleword aligned.
REQ-008 WriteData  input  64  store data.
REQ-009 ReadData  output  64  load data, registered.
REQ-010 Ready  output  1  one-cycle completion pulse.
REQ-011 Busy  output  1  high whenever state is not IDLE.
REQ-012 Error  output  1  one-cycle pulse for a rejected request.

Function
REQ-013 The block SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-014 Requests SHALL be sampled only in IDLE. MemRead, MemWrite, Address and WriteData SHALL be captured internally at the sampling edge.
REQ-015 Input changes after the sampling edge SHALL have no effect on the captured request.
REQ-016 A legal request is exactly one of MemRead or MemWrite high, with Address[2:0]==0 and Address < DEPTH*8.
REQ-017 On a legal request the FSM SHALL go IDLE->ACCESS and load the counter with LATENCY-1.
REQ-018 In ACCESS with counter != 0, the counter SHALL decrement each edge.
REQ-019 In ACCESS with counter == 0, the next edge SHALL perform the access and move to DONE.
REQ-020 A write SHALL store WriteData into entry Address[63:3].
REQ-021 A read SHALL load ReadData from entry Address[63:3].
REQ-022 Ready SHALL be high for exactly the one cycle spent in DONE. DONE->IDLE SHALL be unconditional.
REQ-023 Latency SHALL be as follows: with the request sampled at edge E0, Ready is high between edges E0+LATENCY and E0+LATENCY+1.
REQ-024 ReadData SHALL hold its value until the next completed read; writes and errors SHALL NOT change it.
REQ-025 On an illegal request (both strobes high, misaligned, or out of range) in IDLE, the FSM SHALL stay in IDLE.
REQ-026 For an illegal request, Error SHALL pulse for one cycle after the sampling edge, no memory access SHALL occur, and Ready SHALL stay low.
REQ-027 Requests asserted while Busy is high SHALL be ignored, not queued. The earliest next sample SHALL be the first edge at which the FSM is in IDLE.
REQ-028 A request held high continuously SHALL be re-sampled at each IDLE edge. The requester deasserts after Ready.
REQ-029 With LATENCY=1, ACCESS SHALL last one cycle and Ready SHALL follow one cycle later.
REQ-030 Busy SHALL be high in ACCESS and DONE and low in IDLE.

Reset
REQ-031 reset_n low SHALL immediately (asynchronously) force: state IDLE, counter 0, ReadData 0, Ready 0, Busy 0, Error 0, all memory entries 0.
REQ-032 Reset asserted mid-ACCESS SHALL abort the access: no write is committed and no Ready is issued after release.
REQ-033 After reset_n rises, the first rising edge with a legal request SHALL be a valid sampling edge.

Verification
REQ-034 Write then read, LATENCY=2: write 0xDEADBEEF_CAFEF00D to Address 0x10; Ready pulses at E0+2. Then read 0x10; Ready at E0+2 and ReadData=0xDEADBEEF_CAFEF00D.
REQ-035 Error cases: MemRead=MemWrite=1 at 0x08, read at 0x0C, and read at 0x100 (DEPTH=32) each give an Error pulse, no Ready, and ReadData unchanged.
REQ-036 Busy ignore: a second write to 0x18 asserted during the ACCESS of a write to 0x18 is ignored. Memory holds the first data and a single Ready pulse occurs.
REQ-037 Mid-access reset: reset_n dropped in ACCESS of a write of 0x1234 to 0x20 gives all outputs 0. A subsequent read of 0x20 returns 0.
REQ-038 LATENCY=1: a read of 0x00 after reset gives Ready one cycle after ACCESS and ReadData=0. Back-to-back held MemRead gives Ready every 3 cycles.
REQ-039 Boundary entry: write 0xFFFF_FFFF_FFFF_FFFF to 0xF8 (last entry), then read 0xF8 and 0x00; the results are 0xFFFF_FFFF_FFFF_FFFF and 0 respectively.
